// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch / next-PC path of the single-issue core.
//
// Contents:
//   RESET_VECTOR_DEF / EXC_VECTOR_DEF : default reset and exception addresses
//   PCSRC_SEQ/BR/J/JR                 : encodings of the 2-bit pc_src input
//   state_t                           : pc_sequencer FSM states
//   is_word_aligned()                 : helper for the misalignment trap
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0040_0004;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection.
//
// Picks the target for the instruction that is completing, applies the
// misalignment trap and tells the sequencer whether EPC must capture pc_cur.
//
// Ports:
//   pc_cur         in  32  PC of the completing instruction
//   pc_src         in  2   PCSRC_SEQ/BR/J/JR
//   branch_taken   in  1   branch condition (pc_src=BR only)
//   branch_offset  in  32  sign-extended, pre-shifted branch offset
//   jump_index     in  26  instr_index field of j/jal
//   jr_target      in  32  register value for jr
//   exc_req        in  1   exception raised by the instruction
//   eret           in  1   instruction is eret
//   epc            in  32  current EPC register value
//   target         out 32  final next-PC (EXC_VECTOR on a trap)
//   addr_err       out 1   selected jr/branch/eret target was misaligned
//   epc_load       out 1   EPC must capture pc_cur (exception or trap)
module npc_calc
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [31:0] pc_cur,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] target,
  output logic        addr_err,
  output logic        epc_load
);

  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic        check_align;
  logic        take_exc;

  // All additions wrap modulo 2^32 by construction of the 32-bit sums.
  always_comb begin
    pc_plus4    = pc_cur + 32'd4;
    raw_target  = pc_plus4;
    check_align = 1'b0;
    take_exc    = 1'b0;

    // Exception has priority over eret, which has priority over pc_src.
    if (exc_req) begin
      raw_target = EXC_VECTOR;
      take_exc   = 1'b1;
    end else if (eret) begin
      raw_target  = epc;
      check_align = 1'b1;
    end else begin
      unique case (pc_src)
        PCSRC_SEQ: raw_target = pc_plus4;
        PCSRC_BR: begin
          raw_target  = branch_taken ? (pc_plus4 + branch_offset) : pc_plus4;
          check_align = 1'b1;
        end
        PCSRC_J:   raw_target = {pc_plus4[31:28], jump_index, 2'b00};
        PCSRC_JR: begin
          raw_target  = jr_target;
          check_align = 1'b1;
        end
        default:   raw_target = pc_plus4;
      endcase
    end

    // Sequential and jump targets are aligned whenever pc_cur is, and the
    // exception vector is trusted, so only jr/branch/eret are checked.
    addr_err = check_align && !is_word_aligned(raw_target);
    target   = addr_err ? EXC_VECTOR : raw_target;
    epc_load = take_exc || addr_err;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch / next-PC controller for the single-issue core.
//
// Per instruction: fetch at pc_cur, pulse instr_valid, wait for the core to
// finish (and any stall to clear), then pulse pc_ena with the selected next
// PC. Owns the EPC register used on exception entry and eret.
//
// Handshake: imem_req is held high for the whole FETCH state and the fetch
// completes on the first rising edge where imem_ready=1. core_done is a
// completion event that may be a single-cycle pulse; it is remembered in
// done_seen until the instruction retires. Retirement happens in the first
// EXEC cycle where completion has been seen and stall=0.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   pc_cur          in  32  PC register output
//   pc_ena          out 1   one-cycle PC register write enable
//   pc_next         out 32  PC register data input (holds when pc_ena=0)
//   imem_req        out 1   fetch request (FETCH state)
//   imem_addr       out 32  fetch address (= pc_cur)
//   imem_ready      in  1   fetch complete
//   instr_valid     out 1   one-cycle pulse on the first EXEC cycle
//   core_done       in  1   core finished the current instruction
//   stall           in  1   hold PC update
//   pc_src, branch_taken, branch_offset, jump_index, jr_target,
//   exc_req, eret   in      next-PC selection inputs (see npc_calc)
//   addr_err        out 1   one-cycle pulse: misaligned target trapped
//   epc             out 32  exception program counter
//   state_dbg       out 2   current FSM state
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  input  logic        core_done,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  output logic        addr_err,
  output logic [31:0] epc,
  output state_t      state_dbg
);

  state_t      state;
  logic        instr_valid_q;
  logic        done_seen;
  logic [31:0] pc_next_q;
  logic [31:0] epc_q;

  logic [31:0] target;
  logic        target_misaligned;
  logic        epc_load;
  logic        advance;

  npc_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_calc (
    .pc_cur        (pc_cur),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .exc_req       (exc_req),
    .eret          (eret),
    .epc           (epc_q),
    .target        (target),
    .addr_err      (target_misaligned),
    .epc_load      (epc_load)
  );

  // Retire in the EXEC cycle itself so the PC register loads on the
  // EXEC->FETCH edge and the following FETCH already sees the new pc_cur.
  // pc_ena, pc_next and addr_err are therefore decoded from registered
  // state plus this cycle's inputs rather than registered a cycle later.
  assign advance = (state == S_EXEC) && (core_done || done_seen) && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      instr_valid_q <= 1'b0;
      done_seen     <= 1'b0;
      pc_next_q     <= RESET_VECTOR;
      epc_q         <= RESET_VECTOR;
    end else begin
      instr_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready) begin
            state         <= S_EXEC;
            instr_valid_q <= 1'b1;
            done_seen     <= 1'b0;
          end
        end
        S_EXEC: begin
          if (advance) begin
            state     <= S_FETCH;
            done_seen <= 1'b0;
            pc_next_q <= target;
            if (epc_load) begin
              epc_q <= pc_cur;
            end
          end else if (core_done) begin
            done_seen <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_ena      = advance;
  assign pc_next     = advance ? target : pc_next_q;
  assign addr_err    = advance && target_misaligned;
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc_cur;
  assign instr_valid = instr_valid_q;
  assign epc         = epc_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of single-instruction vectors
// plus hand-written stall and reset sequences.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic        core_done;
  logic        stall;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret;
  logic        addr_err;
  logic [31:0] epc;
  state_t      state_dbg;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_cur        (pc_cur),
    .pc_ena        (pc_ena),
    .pc_next       (pc_next),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .instr_valid   (instr_valid),
    .core_done     (core_done),
    .stall         (stall),
    .pc_src        (pc_src),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .exc_req       (exc_req),
    .eret          (eret),
    .addr_err      (addr_err),
    .epc           (epc),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Bounded wait for the FETCH state; an expired bound counts as a failure.
  task automatic wait_fetch(input string name);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_fetch: got imem_req=%b expected 1 within 20 cycles", name, imem_req);
    end
  endtask

  task automatic clear_ops();
    pc_src        = PCSRC_SEQ;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
    jump_index    = 26'h0;
    jr_target     = 32'h0;
    exc_req       = 1'b0;
    eret          = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [1:0]  src;
    logic        taken;
    logic [31:0] off;
    logic [25:0] idx;
    logic [31:0] jr;
    logic        exc;
    logic        er;
    int          ready_wait;
    logic [31:0] exp_next;
    logic        exp_ae;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  // Drive one instruction through FETCH and EXEC with core_done in the
  // first EXEC cycle, checking each step.
  task automatic run_vec(input vec_t v);
    wait_fetch(v.name);
    pc_cur = v.pc;
    for (int i = 0; i < v.ready_wait; i++) begin
      #1;
      check1({v.name, " req_wait"}, imem_req, 1'b1);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    #1;
    check32({v.name, " imem_addr"}, imem_addr, v.pc);
    @(negedge clk);
    imem_ready    = 1'b0;
    pc_src        = v.src;
    branch_taken  = v.taken;
    branch_offset = v.off;
    jump_index    = v.idx;
    jr_target     = v.jr;
    exc_req       = v.exc;
    eret          = v.er;
    core_done     = 1'b1;
    #1;
    check1({v.name, " instr_valid"}, instr_valid, 1'b1);
    check1({v.name, " imem_req_exec"}, imem_req, 1'b0);
    check1({v.name, " pc_ena"}, pc_ena, 1'b1);
    check32({v.name, " pc_next"}, pc_next, v.exp_next);
    check1({v.name, " addr_err"}, addr_err, v.exp_ae);
    @(negedge clk);
    core_done = 1'b0;
    clear_ops();
    #1;
    check1({v.name, " instr_valid_off"}, instr_valid, 1'b0);
    check1({v.name, " pc_ena_off"}, pc_ena, 1'b0);
    check1({v.name, " addr_err_off"}, addr_err, 1'b0);
    check1({v.name, " refetch"}, imem_req, 1'b1);
    check32({v.name, " pc_next_hold"}, pc_next, v.exp_next);
    check32({v.name, " epc"}, epc, v.exp_epc);
  endtask

  task automatic check_reset_outputs(input string name);
    check1({name, " pc_ena"}, pc_ena, 1'b0);
    check1({name, " imem_req"}, imem_req, 1'b0);
    check1({name, " instr_valid"}, instr_valid, 1'b0);
    check1({name, " addr_err"}, addr_err, 1'b0);
    check32({name, " pc_next"}, pc_next, 32'h0040_0000);
    check32({name, " epc"}, epc, 32'h0040_0000);
    check32({name, " state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  initial begin
    //               name         pc            src        tk  off           idx          jr            exc er  w  exp_next      ae  exp_epc
    vecs[0]  = '{"seq_first",  32'h0040_0000, PCSRC_SEQ, 0, 32'h0,        26'h0,       32'h0,        0, 0, 1, 32'h0040_0004, 0, 32'h0040_0000};
    vecs[1]  = '{"br_taken",   32'h0040_0010, PCSRC_BR,  1, 32'hFFFF_FFF0, 26'h0,       32'h0,        0, 0, 0, 32'h0040_0004, 0, 32'h0040_0000};
    vecs[2]  = '{"br_not",     32'h0040_0010, PCSRC_BR,  0, 32'hFFFF_FFF0, 26'h0,       32'h0,        0, 0, 2, 32'h0040_0014, 0, 32'h0040_0000};
    vecs[3]  = '{"jump",       32'h0040_0020, PCSRC_J,   0, 32'h0,        26'h010_0008, 32'h0,       0, 0, 0, 32'h0040_0020, 0, 32'h0040_0000};
    vecs[4]  = '{"jr_misal",   32'h0040_0020, PCSRC_JR,  0, 32'h0,        26'h0,       32'h0040_0102, 0, 0, 0, 32'h0040_0004, 1, 32'h0040_0020};
    vecs[5]  = '{"exc",        32'h0040_0050, PCSRC_SEQ, 0, 32'h0,        26'h0,       32'h0,        1, 0, 0, 32'h0040_0004, 0, 32'h0040_0050};
    vecs[6]  = '{"eret",       32'h0040_0008, PCSRC_SEQ, 0, 32'h0,        26'h0,       32'h0,        0, 1, 0, 32'h0040_0050, 0, 32'h0040_0050};
    vecs[7]  = '{"exc_eret",   32'h0040_0060, PCSRC_SEQ, 0, 32'h0,        26'h0,       32'h0,        1, 1, 0, 32'h0040_0004, 0, 32'h0040_0060};
    vecs[8]  = '{"jr_ok",      32'h0040_0070, PCSRC_JR,  0, 32'h0,        26'h0,       32'h0040_0200, 0, 0, 0, 32'h0040_0200, 0, 32'h0040_0060};
    vecs[9]  = '{"seq_wrap",   32'hFFFF_FFFC, PCSRC_SEQ, 0, 32'h0,        26'h0,       32'h0,        0, 0, 0, 32'h0000_0000, 0, 32'h0040_0060};
    vecs[10] = '{"br_wrap",    32'hFFFF_FFFC, PCSRC_BR,  1, 32'h0000_0008, 26'h0,      32'h0,        0, 0, 0, 32'h0000_0008, 0, 32'h0040_0060};
    vecs[11] = '{"br_misal",   32'h0040_0080, PCSRC_BR,  1, 32'h0000_0002, 26'h0,      32'h0,        0, 0, 0, 32'h0040_0004, 1, 32'h0040_0080};
    vecs[12] = '{"exc_over_jr",32'h0040_0004, PCSRC_JR,  0, 32'h0,        26'h0,       32'h0000_0003, 1, 0, 0, 32'h0040_0004, 0, 32'h0040_0004};
    vecs[13] = '{"jump_hi",    32'h9000_0010, PCSRC_J,   0, 32'h0,        26'h3FF_FFFF, 32'h0,       0, 0, 0, 32'h9FFF_FFFC, 0, 32'h0040_0004};
    vecs[14] = '{"exc_odd_pc", 32'h0040_0031, PCSRC_SEQ, 0, 32'h0,        26'h0,       32'h0,        1, 0, 0, 32'h0040_0004, 0, 32'h0040_0031};
    vecs[15] = '{"eret_misal", 32'h0040_0100, PCSRC_SEQ, 0, 32'h0,        26'h0,       32'h0,        0, 1, 0, 32'h0040_0004, 1, 32'h0040_0100};

    // ---------------- reset ----------------
    rst_n      = 1'b0;
    pc_cur     = 32'h0040_0000;
    imem_ready = 1'b0;
    core_done  = 1'b0;
    stall      = 1'b0;
    clear_ops();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i]);
    end

    // ---------------- stall with a single-cycle core_done ----------------
    wait_fetch("stall");
    pc_cur     = 32'h0040_0100;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    core_done  = 1'b1;
    stall      = 1'b1;
    #1;
    check1("stall c0 pc_ena", pc_ena, 1'b0);
    @(negedge clk);
    core_done = 1'b0;
    #1;
    check1("stall c1 pc_ena", pc_ena, 1'b0);
    check32("stall c1 state", 32'(state_dbg), 32'(S_EXEC));
    @(negedge clk);
    #1;
    check1("stall c2 pc_ena", pc_ena, 1'b0);
    @(negedge clk);
    stall = 1'b0;
    #1;
    check1("stall release pc_ena", pc_ena, 1'b1);
    check32("stall release pc_next", pc_next, 32'h0040_0104);
    @(negedge clk);
    #1;
    check1("stall after pc_ena", pc_ena, 1'b0);
    check1("stall after refetch", imem_req, 1'b1);

    // ---------------- reset mid-EXEC ----------------
    pc_cur     = 32'h0040_0200;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    check32("mid_exec entered", 32'(state_dbg), 32'(S_EXEC));
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_exec");
    rst_n = 1'b1;

    // ---------------- reset mid-FETCH with imem_ready in flight ----------------
    wait_fetch("rst_fetch");
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_fetch");
    @(negedge clk);
    rst_n      = 1'b1;
    imem_ready = 1'b0;
    #1;
    check1("rst_fetch no instr_valid", instr_valid, 1'b0);
    check32("rst_fetch idle", 32'(state_dbg), 32'(S_IDLE));

    // Recovery: a plain sequential instruction after reset.
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
